fifo_reader: RTL and testbench

Read-side consumer for the single-word dual-clock handoff FIFO, clocked in the slow rd_clk domain. It drains words from the FIFO's empty_n/rd/rd_data port one at a time using a pulse-and-wait handshake, so the same word is never consumed twice. It packs WORDS consecutive words into one wide beat and presents that beat downstream on a valid/ready interface with backpressure.

---
 rtl/fifo_reader.sv | 136 +++++++++++++
 tb/tb_fifo_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Read-side consumer for the dual-clock handoff FIFO: pulses fifo_rd once per word, waits for
// fifo_empty_n to drop, packs WORDS words per beat and offers each beat on a valid/ready port.
module fifo_reader #(
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned WORDS       = 2,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                          rd_clk,
  input  logic                          rst_n,
  input  logic [BUS_WIDTH-1:0]          fifo_rd_data,
  input  logic                          fifo_empty_n,
  output logic                          fifo_rd,
  input  logic                          flush,
  output logic [BUS_WIDTH*WORDS-1:0]    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(WORDS+1)-1:0]    word_idx,
  output logic                          ack_err
);

  localparam int unsigned IdxW  = $clog2(WORDS + 1);
  localparam int unsigned BeatW = BUS_WIDTH * WORDS;

  typedef enum logic [1:0] {StIdle, StRead, StWaitLow} state_e;

  state_e           state_q, state_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ack_err_q, ack_err_d;
  logic [BeatW-1:0] asm_q, asm_d;
  logic             asm_full_q, asm_full_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [BeatW-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             xfer;

  // Assembly moves to the output register whenever that register is free or being drained.
  assign xfer = asm_full_q && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    fifo_rd_d   = fifo_rd_q;
    cnt_d       = cnt_q;
    ack_err_d   = ack_err_q;
    asm_d       = asm_q;
    asm_full_d  = asm_full_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        if (fifo_empty_n && !asm_full_q) begin
          fifo_rd_d = 1'b1;
          state_d   = StRead;
        end
      end
      StRead: begin
        if (!flush) begin
          asm_d[int'(idx_q)*BUS_WIDTH +: BUS_WIDTH] = fifo_rd_data;
          if (idx_q == IdxW'(WORDS - 1)) begin
            asm_full_d = 1'b1;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        fifo_rd_d = 1'b0;
        cnt_d     = '0;
        state_d   = StWaitLow;
      end
      StWaitLow: begin
        // Only a falling empty_n re-arms the read, so one word is never consumed twice.
        if (!fifo_empty_n) begin
          state_d = StIdle;
        end else begin
          if (cnt_q != 8'(ACK_TIMEOUT)) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (cnt_d == 8'(ACK_TIMEOUT)) begin
            ack_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      out_data_d  = asm_q;
      out_valid_d = 1'b1;
      asm_full_d  = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A same-cycle transfer has already taken the full assembly, so it survives the flush.
    if (flush) begin
      idx_d = '0;
      asm_d = '0;
      if (!xfer) begin
        asm_full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      fifo_rd_q   <= 1'b0;
      cnt_q       <= '0;
      ack_err_q   <= 1'b0;
      asm_q       <= '0;
      asm_full_q  <= 1'b0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_rd_q   <= fifo_rd_d;
      cnt_q       <= cnt_d;
      ack_err_q   <= ack_err_d;
      asm_q       <= asm_d;
      asm_full_q  <= asm_full_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign word_idx  = idx_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: directed handshake scenarios, then a random FIFO/sink run scored
// against a word-queue model of the packing rules.
module tb_fifo_reader;

  localparam int unsigned BusW  = 16;
  localparam int unsigned Words = 2;
  localparam int unsigned AckTo = 15;
  localparam int unsigned IdxW  = $clog2(Words + 1);
  localparam int unsigned BeatW = BusW * Words;

  logic             rd_clk = 1'b0;
  logic             rst_n;
  logic [BusW-1:0]  fifo_rd_data;
  logic             fifo_empty_n;
  logic             fifo_rd;
  logic             flush;
  logic [BeatW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IdxW-1:0]  word_idx;
  logic             ack_err;

  always #5 rd_clk = ~rd_clk;

  fifo_reader #(
    .BUS_WIDTH  (BusW),
    .WORDS      (Words),
    .ACK_TIMEOUT(AckTo)
  ) u_dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty_n(fifo_empty_n),
    .fifo_rd     (fifo_rd),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .word_idx    (word_idx),
    .ack_err     (ack_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rd_pulses = 0;

  // Random-phase model state: FIFO emulator phase and the expected word/beat stream.
  int               phase;      // 0 gap, 1 word offered, 2 holding after read
  int               hold_cnt;
  int               gap_cnt;
  int               consumed;
  int               accepted;
  logic [BusW-1:0]  part_q[$];
  logic [BeatW-1:0] beats_q[$];
  logic             hold_prev;
  logic [BeatW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle; outputs are stable there.
  task automatic cyc();
    @(negedge rd_clk);
    if (fifo_rd === 1'b1) rd_pulses++;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    fifo_empty_n = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    fifo_rd_data = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  // Offer one word, wait for its read pulse, keep empty_n high for 'hold' extra cycles, then
  // drop it for one cycle. Returns in the following IDLE cycle.
  task automatic feed(input logic [BusW-1:0] w, input int hold, input logic fl,
                      output logic ov_first);
    int n = 0;
    fifo_rd_data = w;
    fifo_empty_n = 1'b1;
    while (fifo_rd !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("feed_rd", fifo_rd, 1);
    flush = fl;
    cyc();
    flush    = 1'b0;
    ov_first = out_valid;
    repeat (hold) cyc();
    fifo_empty_n = 1'b0;
    cyc();
  endtask

  task automatic rand_cycle(input bit active, input bit drain, input int k);
    logic [BeatW-1:0] beat;
    logic [BeatW-1:0] exp;
    cyc();
    if (hold_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, prev_data);
    end
    if (fifo_rd === 1'b1) begin
      check("rd_only_when_offered", (phase == 1), 1);
      check("rd_word_idx", word_idx, consumed % Words);
      check("rd_occupancy", ((consumed - accepted * Words) <= 2 * Words - 1), 1);
      part_q.push_back(fifo_rd_data);
      consumed++;
      if (part_q.size() == Words) begin
        beat = '0;
        for (int i = 0; i < Words; i++) beat[i*BusW +: BusW] = part_q[i];
        beats_q.push_back(beat);
        part_q.delete();
      end
      phase    = 2;
      hold_cnt = $urandom_range(0, 3);
    end else begin
      case (phase)
        0: begin
          if (gap_cnt > 0) gap_cnt--;
          else if (active) begin
            phase        = 1;
            fifo_empty_n = 1'b1;
            fifo_rd_data = BusW'($urandom);
          end
        end
        2: begin
          if (hold_cnt > 0) hold_cnt--;
          else begin
            phase        = 0;
            fifo_empty_n = 1'b0;
            gap_cnt      = $urandom_range(0, 3);
          end
        end
        default: ;
      endcase
    end
    out_ready = drain ? 1'b1 : ((k % 200) >= 40 && $urandom_range(0, 3) != 0);
    if (out_valid === 1'b1 && out_ready) begin
      if (beats_q.size() == 0) begin
        check("beat_expected_available", beats_q.size(), 1);
      end else begin
        exp = beats_q.pop_front();
        check("beat_data", out_data, exp);
      end
      accepted++;
    end
    hold_prev = (out_valid === 1'b1) && !out_ready;
    prev_data = out_data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ov;
    int   rd0;

    // Reset held with a word on offer.
    rst_n        = 1'b0;
    fifo_empty_n = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b0;
    fifo_rd_data = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_rd", fifo_rd, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_err", ack_err, 0);
    end
    rst_n     = 1'b1;
    rd_pulses = 0;
    cyc();
    check("rst_first_rd", fifo_rd, 1);

    // Packing two words into one beat.
    feed(16'h1234, 0, 1'b0, ov);
    feed(16'hABCD, 0, 1'b0, ov);
    check("pack_t1_valid", ov, 0);
    check("pack_valid", out_valid, 1);
    check("pack_data", out_data, 32'hABCD1234);
    check("pack_rd_count", rd_pulses, 2);
    check("pack_idx", word_idx, 0);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("pack_drain", out_valid, 0);

    // empty_n stuck high after a read must not trigger another read.
    rd0 = rd_pulses;
    feed(16'h0A0A, 5, 1'b0, ov);
    check("ndr_rd_count", rd_pulses - rd0, 1);
    check("ndr_idx", word_idx, 1);
    repeat (3) cyc();
    check("ndr_idle_no_rd", rd_pulses - rd0, 1);
    feed(16'h0B0B, 0, 1'b0, ov);
    check("ndr_data", out_data, 32'h0B0B0A0A);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Backpressure: output and assembly both full, no fifth read.
    do_reset();
    rd0 = rd_pulses;
    feed(16'h0001, 0, 1'b0, ov);
    feed(16'h0002, 0, 1'b0, ov);
    feed(16'h0003, 0, 1'b0, ov);
    feed(16'h0004, 0, 1'b0, ov);
    fifo_rd_data = 16'h0005;
    fifo_empty_n = 1'b1;
    repeat (6) cyc();
    check("bp_no_5th", rd_pulses - rd0, 4);
    check("bp_held_valid", out_valid, 1);
    check("bp_held_data", out_data, 32'h00020001);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("bp_b2b_valid", out_valid, 1);
    check("bp_b2b_data", out_data, 32'h00040003);

    // Flush in the READ cycle discards the partial beat and the word being read.
    do_reset();
    feed(16'h1111, 0, 1'b0, ov);
    check("fl_idx_before", word_idx, 1);
    feed(16'h5555, 0, 1'b1, ov);
    check("fl_idx", word_idx, 0);
    check("fl_no_beat", out_valid, 0);
    feed(16'h2222, 0, 1'b0, ov);
    feed(16'h3333, 0, 1'b0, ov);
    check("fl_valid", out_valid, 1);
    check("fl_data", out_data, 32'h33332222);

    // Handshake timeout.
    do_reset();
    rd0          = rd_pulses;
    fifo_rd_data = 16'h7777;
    fifo_empty_n = 1'b1;
    for (int n = 0; n < 20 && fifo_rd !== 1'b1; n++) cyc();
    check("to_rd", fifo_rd, 1);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == AckTo || i == AckTo + 1) check("to_err_edge", ack_err, (i > AckTo));
    end
    fifo_empty_n = 1'b0;
    repeat (3) cyc();
    check("to_sticky", ack_err, 1);
    check("to_rd_count", rd_pulses - rd0, 1);

    // Random FIFO timing and sink backpressure against the word-queue model.
    do_reset();
    phase     = 0;
    hold_cnt  = 0;
    gap_cnt   = 0;
    consumed  = 0;
    accepted  = 0;
    hold_prev = 1'b0;
    prev_data = '0;
    part_q.delete();
    beats_q.delete();
    for (int k = 0; k < 4000; k++) rand_cycle(1'b1, 1'b0, k);
    for (int k = 0; k < 200; k++) rand_cycle(1'b0, 1'b1, k);
    check("rand_progress", (consumed > 100), 1);
    check("rand_drain_empty", beats_q.size(), 0);
    check("rand_drain_valid", out_valid, 0);
    check("rand_final_idx", word_idx, consumed % Words);
    check("rand_no_ack_err", ack_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
